glay_kernel_setup_req_gen: RTL and testbench

//  Upstream feeder of the kernel setup stage.

---
 rtl/glay_globals_pkg.sv | 7 +
 rtl/glay_req_pkg.sv | 20 ++
 rtl/glay_kernel_setup_req_gen.sv | 143 ++++++++++++++
 tb/tb_glay_kernel_setup_req_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/glay_globals_pkg.sv
// Global constants shared across the GLAY kernel datapath.
package glay_globals_pkg;

  localparam int unsigned GLAY_LINE_BYTES = 64;
  localparam int unsigned GLAY_LINE_SHIFT = $clog2(GLAY_LINE_BYTES);

endpackage

// File: rtl/glay_req_pkg.sv
// Types for the kernel setup request generator.
package glay_req_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StIssue,
    StDone
  } req_gen_state;

  localparam int unsigned GLAY_REQ_ADDR_WIDTH = 64;
  localparam int unsigned GLAY_REQ_ID_WIDTH   = 8;

  typedef struct packed {
    logic [GLAY_REQ_ADDR_WIDTH-1:0] addr;
    logic [GLAY_REQ_ID_WIDTH-1:0]   id;
    logic                           last;
  } GlaySetupLineRequest;

endpackage

// File: rtl/glay_kernel_setup_req_gen.sv
// Walks one (base, length) descriptor region as line-aligned read requests, one per
// unstalled cycle, then pulses done. One region in flight at a time.
module glay_kernel_setup_req_gen
  import glay_globals_pkg::*;
  import glay_req_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 32,
  parameter int unsigned LINE_BYTES = GLAY_LINE_BYTES,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [LEN_WIDTH-1:0]  byte_len_in,
  input  logic                  fifo_prog_full,
  input  logic                  fifo_setup_in,
  output logic                  req_valid_out,
  output logic [ADDR_WIDTH-1:0] req_addr_out,
  output logic [ID_WIDTH-1:0]   req_id_out,
  output logic                  req_last_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int unsigned LineShift = $clog2(LINE_BYTES);
  localparam int unsigned LineW     = ADDR_WIDTH - LineShift;
  localparam int unsigned SumW      = ADDR_WIDTH + 1;
  localparam int unsigned SpanW     = SumW - LineShift;
  localparam int unsigned CntW      = LEN_WIDTH + 1;

  // Same shape as GlaySetupLineRequest, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic                  last;
  } line_req_t;

  req_gen_state          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LineW-1:0]      line_q, line_d;
  logic [CntW-1:0]       remaining_q, remaining_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  line_req_t             req_q, req_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [SumW-1:0]       end_addr;
  logic [SpanW-1:0]      last_line;
  logic [SpanW-1:0]      line_span;
  logic                  go;

  // The extra sum bit keeps the line count right when the region wraps the address space.
  assign end_addr  = {1'b0, base_q} + SumW'(len_q) - SumW'(1);
  assign last_line = end_addr[SumW-1:LineShift];
  assign line_span = last_line - {1'b0, base_q[ADDR_WIDTH-1:LineShift]} + SpanW'(1);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    line_d      = line_q;
    remaining_d = remaining_q;
    id_d        = id_q;
    req_d       = req_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    go          = !fifo_prog_full && !fifo_setup_in;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          base_d  = base_addr_in;
          len_d   = byte_len_in;
          state_d = StLatch;
        end
      end
      StLatch: begin
        line_d      = base_q[ADDR_WIDTH-1:LineShift];
        remaining_d = line_span[CntW-1:0];
        state_d     = (len_q == '0) ? StDone : StIssue;
      end
      StIssue: begin
        if (go) begin
          valid_d      = 1'b1;
          req_d.addr   = {line_q, {LineShift{1'b0}}};
          req_d.id     = id_q;
          req_d.last   = (remaining_q == CntW'(1));
          id_d         = id_q + ID_WIDTH'(1);
          line_d       = line_q + LineW'(1);
          remaining_d  = remaining_q - CntW'(1);
          if (remaining_q == CntW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StLatch) || (state_d == StIssue);
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      line_q      <= '0;
      remaining_q <= '0;
      id_q        <= '0;
      req_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      line_q      <= line_d;
      remaining_q <= remaining_d;
      id_q        <= id_d;
      req_q       <= req_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign req_valid_out = valid_q;
  assign req_addr_out  = req_q.addr;
  assign req_id_out    = req_q.id;
  assign req_last_out  = req_q.last;
  assign busy_out      = busy_q;
  assign done_out      = done_q;

endmodule

// File: tb/tb_glay_kernel_setup_req_gen.sv
// Randomized bench for glay_kernel_setup_req_gen against a line-list reference model.
module tb_glay_kernel_setup_req_gen;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        start_in;
  logic [63:0] base_addr_in;
  logic [31:0] byte_len_in;
  logic        fifo_prog_full;
  logic        fifo_setup_in;

  logic        req_valid_out, req_last_out, busy_out, done_out;
  logic [63:0] req_addr_out;
  logic [7:0]  req_id_out;

  logic        v2, l2, b2, d2;
  logic [63:0] a2;
  logic [1:0]  id2;

  always #5 ap_clk = ~ap_clk;

  glay_kernel_setup_req_gen u_dut (
    .ap_clk         (ap_clk),
    .areset         (areset),
    .start_in       (start_in),
    .base_addr_in   (base_addr_in),
    .byte_len_in    (byte_len_in),
    .fifo_prog_full (fifo_prog_full),
    .fifo_setup_in  (fifo_setup_in),
    .req_valid_out  (req_valid_out),
    .req_addr_out   (req_addr_out),
    .req_id_out     (req_id_out),
    .req_last_out   (req_last_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  // Narrow-id instance to exercise id wrap quickly.
  glay_kernel_setup_req_gen #(
    .ID_WIDTH (2)
  ) u_dut_id2 (
    .ap_clk         (ap_clk),
    .areset         (areset),
    .start_in       (start_in),
    .base_addr_in   (base_addr_in),
    .byte_len_in    (byte_len_in),
    .fifo_prog_full (fifo_prog_full),
    .fifo_setup_in  (fifo_setup_in),
    .req_valid_out  (v2),
    .req_addr_out   (a2),
    .req_id_out     (id2),
    .req_last_out   (l2),
    .busy_out       (b2),
    .done_out       (d2)
  );

  typedef struct {
    logic [63:0] addr;
    bit          last;
  } exp_req_t;

  exp_req_t    exp_q[$];
  int unsigned exp_seq;
  logic [63:0] hold_addr;
  logic [7:0]  hold_id8;
  logic [1:0]  hold_id2;
  logic        hold_last;
  int          checks;
  int          errors;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: every line touched by [base, base+len) in ascending order, addresses mod 2**64.
  task automatic build_expect(input logic [63:0] base, input logic [31:0] len);
    logic [64:0] first_l, last_l, l, byte_addr;
    exp_req_t    e;
    if (len == 0) return;
    first_l = {1'b0, base} / 65'd64;
    last_l  = ({1'b0, base} + {33'b0, len} - 65'd1) / 65'd64;
    for (l = first_l; l <= last_l; l++) begin
      byte_addr = l * 65'd64;
      e.addr    = byte_addr[63:0];
      e.last    = (l == last_l);
      exp_q.push_back(e);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_seq   = 0;
    hold_addr = '0;
    hold_id8  = '0;
    hold_id2  = '0;
    hold_last = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"}, {req_valid_out, v2}, 2'b00);
    check_val({tag, "_addr"}, req_addr_out | a2, 64'd0);
    check_val({tag, "_id"}, {req_id_out, id2}, 10'd0);
    check_val({tag, "_last"}, {req_last_out, l2}, 2'b00);
    check_val({tag, "_busy"}, {busy_out, b2}, 2'b00);
    check_val({tag, "_done"}, {done_out, d2}, 2'b00);
  endtask

  // stall_mode: 0 none, 1 random prog_full/setup_in, 2 prog_full for three cycles mid-burst.
  task automatic run_region(input logic [63:0] base, input logic [31:0] len,
                            input int stall_mode, input bit extra_start, input int abort_after);
    int       k, last_k, beats;
    bit       stall_prev, done_seen, exp_valid, exp_done, exp_busy;
    int       r;
    exp_req_t e;

    build_expect(base, len);
    base_addr_in = base;
    byte_len_in  = len;
    start_in     = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    start_in     = 1'b0;
    base_addr_in = {$urandom, $urandom};
    byte_len_in  = $urandom_range(1, 300);
    check_val("busy_rise", {busy_out, b2}, 2'b11);
    check_val("valid_k0", {req_valid_out, v2}, 2'b00);

    stall_prev = 1'b0;
    last_k     = -1;
    beats      = 0;
    done_seen  = 1'b0;
    for (k = 1; k <= 400 && !done_seen; k++) begin
      @(negedge ap_clk);
      exp_valid = (k >= 2) && (exp_q.size() > 0) && !stall_prev;
      check_val("valid", {req_valid_out, v2}, {exp_valid, exp_valid});
      if (req_valid_out && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("addr", req_addr_out, e.addr);
        check_val("addr_w2", a2, e.addr);
        check_val("id", req_id_out, 64'(exp_seq % 256));
        check_val("id_w2", id2, 64'(exp_seq % 4));
        check_val("last", {req_last_out, l2}, {e.last, e.last});
        hold_addr = e.addr;
        hold_id8  = 8'(exp_seq % 256);
        hold_id2  = 2'(exp_seq % 4);
        hold_last = e.last;
        exp_seq++;
        beats++;
        if (exp_q.size() == 0) last_k = k;
      end else if (!req_valid_out) begin
        check_val("hold_addr", req_addr_out, hold_addr);
        check_val("hold_id", {req_id_out, id2}, {hold_id8, hold_id2});
        check_val("hold_last", req_last_out, hold_last);
      end

      if (abort_after > 0 && beats == abort_after) begin
        areset = 1'b1;
        @(negedge ap_clk);
        check_all_zero("abort");
        areset = 1'b0;
        reset_model();
        repeat (4) begin
          @(negedge ap_clk);
          check_val("abort_quiet", {req_valid_out, v2, done_out, d2, busy_out}, 5'd0);
        end
        return;
      end

      exp_done = (len == 0) ? (k == 2) : (last_k >= 0 && k == last_k + 1);
      check_val("done", {done_out, d2}, {exp_done, exp_done});
      exp_busy = (exp_q.size() > 0);
      check_val("busy", {busy_out, b2}, {exp_busy, exp_busy});
      if (done_out) done_seen = 1'b1;

      start_in = extra_start && (k == 3);
      fifo_prog_full = 1'b0;
      fifo_setup_in  = 1'b0;
      if (stall_mode == 1) begin
        r = $urandom_range(0, 3);
        fifo_prog_full = (r == 1);
        fifo_setup_in  = (r == 2);
      end else if (stall_mode == 2) begin
        fifo_prog_full = (k >= 3 && k <= 5);
      end
      stall_prev = fifo_prog_full | fifo_setup_in;
    end

    start_in       = 1'b0;
    fifo_prog_full = 1'b0;
    fifo_setup_in  = 1'b0;
    check_val("done_seen", done_seen, 1);
    check_val("drained", exp_q.size(), 0);
    exp_q.delete();
    // Nothing may follow done, even after an ignored extra start.
    repeat (3) begin
      @(negedge ap_clk);
      check_val("post_done_quiet", {req_valid_out, v2, done_out}, 3'd0);
    end
  endtask

  initial begin
    logic [63:0] rb;
    logic [31:0] rl;
    checks         = 0;
    errors         = 0;
    reset_model();
    areset         = 1'b1;
    start_in       = 1'b0;
    base_addr_in   = '0;
    byte_len_in    = '0;
    fifo_prog_full = 1'b0;
    fifo_setup_in  = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_all_zero("reset");
    areset = 1'b0;
    @(negedge ap_clk);
    check_all_zero("idle");

    run_region(64'h1000, 32'd256, 0, 1'b0, 0);
    run_region(64'h103C, 32'd8, 0, 1'b0, 0);
    run_region(64'h2000, 32'd0, 0, 1'b0, 0);
    run_region(64'h3000, 32'd512, 2, 1'b0, 0);
    run_region(64'h4000, 32'd512, 0, 1'b0, 2);
    run_region(64'h5000, 32'd384, 0, 1'b1, 0);
    run_region(64'hFFFF_FFFF_FFFF_FFD0, 32'd200, 1, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) rb[5:0] = 6'd0;
      rl = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 700));
      run_region(rb, rl, $urandom_range(0, 1), ($urandom_range(0, 3) == 0) && (rl > 32'd256),
                 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
